// File: rtl/team_06_button_ctrl.sv
// team_06 player-input receive block: five raw pushbuttons are synchronized,
// debounced and turned into one-cycle press events. The events drive the
// game heading and the run/pause state.

// Per-button conditioner: 2-flop synchronizer, debounce counter, and a
// registered rising-edge event on the debounced level.
module team_06_button_ctrl_db #(
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic btn,
    output logic rise
);
    logic             s1, s2, stable;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic             flip;

    assign cnt_inc = cnt + CNT_W'(1);
    // The level flips on the edge where the count of disagreeing cycles
    // would reach DEBOUNCE_CYCLES.
    assign flip    = (s2 != stable) && (cnt_inc == CNT_W'(DEBOUNCE_CYCLES));

    // Synchronizer, debounce counter, stable level and press event.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else if (!en) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            // Event is raised on the same edge the stable level goes 0->1.
            rise <= flip & s2;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (flip) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end
endmodule

module team_06_button_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_start_pause,
    output logic [4:0] btn_pulse,
    output logic [1:0] dir,
    output logic       dir_change,
    output logic       running,
    output logic [7:0] press_cnt
);
    localparam int NUM_BTN = 5;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic {
        PAUSED  = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    logic [NUM_BTN-1:0] btn_raw;
    run_state_t         state, state_nxt;
    logic               cand_vld, accept;
    logic [1:0]         cand, dir_rev;

    assign btn_raw = {btn_start_pause, btn_down, btn_up, btn_left, btn_right};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        team_06_button_ctrl_db #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk (clk),
            .nrst(nrst),
            .en  (en),
            .btn (btn_raw[i]),
            .rise(btn_pulse[i])
        );
    end

    assign running = (state == RUNNING);

    // Run/pause state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)    state <= PAUSED;
        else if (!en) state <= PAUSED;
        else          state <= state_nxt;
    end

    // Start/pause event toggles the run state.
    always_comb begin
        state_nxt = state;
        if (btn_pulse[4]) state_nxt = (state == RUNNING) ? PAUSED : RUNNING;
    end

    // Pick the highest-priority direction event; lower ones are dropped even
    // when the winner is later rejected.
    always_comb begin
        cand_vld = 1'b0;
        cand     = DIR_RIGHT;
        if (btn_pulse[0]) begin
            cand_vld = 1'b1;
            cand     = DIR_RIGHT;
        end else if (btn_pulse[1]) begin
            cand_vld = 1'b1;
            cand     = DIR_LEFT;
        end else if (btn_pulse[2]) begin
            cand_vld = 1'b1;
            cand     = DIR_UP;
        end else if (btn_pulse[3]) begin
            cand_vld = 1'b1;
            cand     = DIR_DOWN;
        end
    end

    // Reverse heading pairs right/left and up/down (differ only in bit 0).
    // running is the pre-toggle value, so a same-cycle start/pause does not
    // affect judging the direction event.
    assign dir_rev = {dir[1], ~dir[0]};
    assign accept  = running && cand_vld && (cand != dir) && (cand != dir_rev);

    // Heading, change strobe and accepted-change counter.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dir        <= DIR_RIGHT;
            dir_change <= 1'b0;
            press_cnt  <= 8'd0;
        end else if (!en) begin
            dir        <= DIR_RIGHT;
            dir_change <= 1'b0;
            press_cnt  <= 8'd0;
        end else begin
            dir_change <= accept;
            if (accept) begin
                dir       <= cand;
                press_cnt <= press_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_team_06_button_ctrl.sv
// Self-checking bench for team_06_button_ctrl. Press events and heading
// changes are predicted when stimulus is driven and queued; a negedge monitor
// pops and compares them as the DUT produces them.
module tb_team_06_button_ctrl;
    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       en = 1'b1;
    logic [4:0] b = 5'b0;

    logic [4:0] pulse1, pulse4;
    logic [1:0] dir1, dir4;
    logic       dc1, dc4, run1, run4;
    logic [7:0] cnt1, cnt4;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    bit sel = 1'b0;           // 0: monitor the DEBOUNCE_CYCLES=1 DUT, 1: the =4 DUT

    bit         m_run = 1'b0;
    logic [1:0] m_dir = 2'b00;
    logic [7:0] m_cnt = 8'd0;

    typedef struct { int cyc; logic [4:0] val; } pev_t;
    typedef struct { int cyc; logic [1:0] dir; logic [7:0] cnt; } dev_t;
    pev_t pq[$];
    dev_t dq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    team_06_button_ctrl #(.DEBOUNCE_CYCLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .nrst(nrst), .en(en),
        .btn_right(b[0]), .btn_left(b[1]), .btn_up(b[2]), .btn_down(b[3]),
        .btn_start_pause(b[4]),
        .btn_pulse(pulse1), .dir(dir1), .dir_change(dc1), .running(run1),
        .press_cnt(cnt1)
    );

    team_06_button_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut4 (
        .clk(clk), .nrst(nrst), .en(en),
        .btn_right(b[0]), .btn_left(b[1]), .btn_up(b[2]), .btn_down(b[3]),
        .btn_start_pause(b[4]),
        .btn_pulse(pulse4), .dir(dir4), .dir_change(dc4), .running(run4),
        .press_cnt(cnt4)
    );

    // Scoreboard monitor: every nonzero btn_pulse and every dir_change must
    // match the next queued expectation, including the cycle it appears in.
    always @(negedge clk) begin
        pev_t pe;
        dev_t de;
        logic [4:0] mp;
        logic       mdc;
        logic [1:0] mdir;
        logic [7:0] mcnt;
        mp   = sel ? pulse4 : pulse1;
        mdc  = sel ? dc4 : dc1;
        mdir = sel ? dir4 : dir1;
        mcnt = sel ? cnt4 : cnt1;
        if (mp !== 5'b0) begin
            n_total++;
            if (pq.size() == 0) begin
                $display("FAIL unexpected_pulse cyc=%0d got=%b exp=none", cyc, mp);
            end else begin
                pe = pq.pop_front();
                if (pe.cyc != cyc || pe.val !== mp)
                    $display("FAIL pulse got=%b@%0d exp=%b@%0d", mp, cyc, pe.val, pe.cyc);
                else
                    n_pass++;
            end
        end
        if (mdc !== 1'b0) begin
            n_total++;
            if (dq.size() == 0) begin
                $display("FAIL unexpected_dir_change cyc=%0d dir=%b cnt=%0d", cyc, mdir, mcnt);
            end else begin
                de = dq.pop_front();
                if (de.cyc != cyc || de.dir !== mdir || de.cnt !== mcnt)
                    $display("FAIL dir_change got dir=%b cnt=%0d @%0d exp dir=%b cnt=%0d @%0d",
                             mdir, mcnt, cyc, de.dir, de.cnt, de.cyc);
                else
                    n_pass++;
            end
        end
    end

    function automatic logic [1:0] rev_of(input logic [1:0] d);
        case (d)
            2'b00:   return 2'b01;
            2'b01:   return 2'b00;
            2'b10:   return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    // One-cycle press on the DEBOUNCE_CYCLES=1 DUT; predicts its outputs.
    task automatic press(input logic [4:0] mask);
        logic [1:0] cand;
        bit         has;
        @(negedge clk);
        b = mask;
        if (mask != 5'b0) pq.push_back('{cyc + 3, mask});
        has  = 1'b0;
        cand = 2'b00;
        if (mask[0])      begin has = 1'b1; cand = 2'b00; end
        else if (mask[1]) begin has = 1'b1; cand = 2'b01; end
        else if (mask[2]) begin has = 1'b1; cand = 2'b10; end
        else if (mask[3]) begin has = 1'b1; cand = 2'b11; end
        if (m_run && has && cand != m_dir && cand != rev_of(m_dir)) begin
            m_dir = cand;
            m_cnt = m_cnt + 8'd1;
            dq.push_back('{cyc + 4, m_dir, m_cnt});
        end
        if (mask[4]) m_run = !m_run;
        @(negedge clk);
        b = 5'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        m_run = 1'b0; m_dir = 2'b00; m_cnt = 8'd0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0; en = 1'b1; b = 5'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({pulse1, dir1, dc1, run1, cnt1, pulse4, dir4, dc4, run4, cnt4} !== 34'b0)
            $display("FAIL reset_outputs got=%h exp=0",
                     {pulse1, dir1, dc1, run1, cnt1, pulse4, dir4, dc4, run4, cnt4});
        else n_pass++;
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({pulse1, dir1, dc1, run1, cnt1} !== 17'b0)
            $display("FAIL post_reset_idle got=%h exp=0", {pulse1, dir1, dc1, run1, cnt1});
        else n_pass++;
    endtask

    task automatic test_start();
        press(5'b10000);
        n_total++;
        if (run1 !== 1'b1 || dir1 !== 2'b00 || cnt1 !== 8'd0)
            $display("FAIL start run=%b dir=%b cnt=%0d exp run=1 dir=00 cnt=0", run1, dir1, cnt1);
        else n_pass++;
    endtask

    task automatic test_turns();
        press(5'b00100);
        n_total++;
        if (dir1 !== 2'b10 || cnt1 !== 8'd1)
            $display("FAIL turn_up dir=%b cnt=%0d exp dir=10 cnt=1", dir1, cnt1);
        else n_pass++;
        press(5'b01000);
        n_total++;
        if (dir1 !== 2'b10 || cnt1 !== 8'd1)
            $display("FAIL reverse_reject dir=%b cnt=%0d exp dir=10 cnt=1", dir1, cnt1);
        else n_pass++;
        press(5'b00001);
        n_total++;
        if (dir1 !== 2'b00 || cnt1 !== 8'd2)
            $display("FAIL turn_right dir=%b cnt=%0d exp dir=00 cnt=2", dir1, cnt1);
        else n_pass++;
    endtask

    task automatic test_paused();
        press(5'b10000);
        n_total++;
        if (run1 !== 1'b0)
            $display("FAIL pause running=%b exp=0", run1);
        else n_pass++;
        press(5'b00010);
        n_total++;
        if (dir1 !== 2'b00 || cnt1 !== 8'd2)
            $display("FAIL paused_ignore dir=%b cnt=%0d exp dir=00 cnt=2", dir1, cnt1);
        else n_pass++;
        press(5'b10000);
        n_total++;
        if (run1 !== 1'b1)
            $display("FAIL resume running=%b exp=1", run1);
        else n_pass++;
    endtask

    task automatic test_priority();
        press(5'b00100);
        press(5'b00011);
        n_total++;
        if (dir1 !== 2'b00 || cnt1 !== 8'd4)
            $display("FAIL right_over_left dir=%b cnt=%0d exp dir=00 cnt=4", dir1, cnt1);
        else n_pass++;
        press(5'b00110);
        n_total++;
        if (dir1 !== 2'b00 || cnt1 !== 8'd4)
            $display("FAIL lower_discarded dir=%b cnt=%0d exp dir=00 cnt=4", dir1, cnt1);
        else n_pass++;
        n_total++;
        if (pq.size() != 0 || dq.size() != 0)
            $display("FAIL missing_events pulses=%0d dirs=%0d exp=0", pq.size(), dq.size());
        else n_pass++;
    endtask

    task automatic test_debounce();
        logic [8:0] bounce;
        bounce = 9'b011101101;   // LSB first: 1-high, low, 2-high, low, 3-high, low
        sel = 1'b1;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            b[0] = bounce[i];
        end
        @(negedge clk);
        b[0] = 1'b1;
        pq.push_back('{cyc + 6, 5'b00001});
        repeat (10) @(negedge clk);
        b[0] = 1'b0;
        repeat (12) @(negedge clk);
        n_total++;
        if (pq.size() != 0)
            $display("FAIL debounce_pulse_missing pending=%0d exp=0", pq.size());
        else n_pass++;
        sel = 1'b0;
    endtask

    task automatic test_wrap_reset();
        int c;
        do_reset();
        press(5'b10000);
        for (int i = 0; i < 256; i++) press((i % 2 == 0) ? 5'b00100 : 5'b00001);
        n_total++;
        if (cnt1 !== 8'd0 || dir1 !== 2'b00 || run1 !== 1'b1)
            $display("FAIL cnt_wrap cnt=%0d dir=%b run=%b exp cnt=0 dir=00 run=1", cnt1, dir1, run1);
        else n_pass++;
        press(5'b00100);
        // Asynchronous reset between clock edges, with start held through it.
        @(negedge clk);
        #2;
        nrst = 1'b0;
        b = 5'b10000;
        m_run = 1'b0; m_dir = 2'b00; m_cnt = 8'd0;
        #1;
        n_total++;
        if ({pulse1, dir1, dc1, run1, cnt1} !== 17'b0)
            $display("FAIL async_reset got=%h exp=0", {pulse1, dir1, dc1, run1, cnt1});
        else n_pass++;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        c = cyc;
        pq.push_back('{c + 3, 5'b10000});
        m_run = 1'b1;
        repeat (8) @(negedge clk);
        b = 5'b0;
        repeat (4) @(negedge clk);
        n_total++;
        if (run1 !== 1'b1 || pq.size() != 0)
            $display("FAIL held_through_reset run=%b pending=%0d exp run=1 pending=0", run1, pq.size());
        else n_pass++;
        press(5'b00100);
        @(negedge clk);
        en = 1'b0;
        m_run = 1'b0; m_dir = 2'b00; m_cnt = 8'd0;
        @(posedge clk);
        #1;
        n_total++;
        if (run1 !== 1'b0 || dir1 !== 2'b00 || cnt1 !== 8'd0)
            $display("FAIL en_clear run=%b dir=%b cnt=%0d exp run=0 dir=00 cnt=0", run1, dir1, cnt1);
        else n_pass++;
        @(negedge clk);
        en = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if (pq.size() != 0 || dq.size() != 0)
            $display("FAIL final_events pulses=%0d dirs=%0d exp=0", pq.size(), dq.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_turns();
        test_paused();
        test_priority();
        test_debounce();
        test_wrap_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout cyc=%0d", cyc);
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "timeout");
    end
endmodule
